// File: rtl/mem_bank_pkg.sv
// Shared types for the bank-select sequencer: CPU operation codes and FSM states.
package mem_bank_pkg;

    typedef enum logic [1:0] {
        OP_SET  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_NOP  = 2'b11
    } bank_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_COMMIT
    } bank_state_e;

endpackage

// File: rtl/mem_bank_stack.sv
// LIFO of saved bank indices. Callers must not push when full or pop when empty.
module mem_bank_stack #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             top,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH + 1);

    // Sized to the pointer range so every index is in bounds; entries >= DEPTH are never written.
    logic [WIDTH-1:0] mem [0:(1 << PW) - 1];

    always_ff @(posedge clk) begin
        if (rst)
            depth <= '0;
        else if (push)
            depth <= depth + PW'(1);
        else if (pop)
            depth <= depth - PW'(1);
    end

    // NOTE: the storage array has no reset; only the pointer defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[depth] <= din;
    end

    assign full  = (depth == PW'(DEPTH));
    assign empty = (depth == '0);
    assign top   = mem[depth - PW'(1)];

endmodule

// File: rtl/mem_bank_ctrl.sv
// Bank-select sequencer: accepts SET/PUSH/POP, waits out memory accesses, then
// pulses the bank register load-enable once per committed operation.
module mem_bank_ctrl
    import mem_bank_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         op_valid,
    input  logic [1:0]                   op_code,
    input  logic [WIDTH-1:0]             op_bank,
    output logic                         op_ready,
    input  logic                         mem_busy,
    output logic                         bank_ce,
    output logic [WIDTH-1:0]             new_bank,
    output logic [WIDTH-1:0]             cur_bank,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         err,
    input  logic                         err_clr
);

    bank_state_e      state;
    bank_op_e         op;
    logic [WIDTH-1:0] pend_bank;
    logic [WIDTH-1:0] stk_top;
    logic             stk_full;
    logic             stk_empty;
    logic             accept;
    logic             stk_push;
    logic             stk_pop;

    assign op     = bank_op_e'(op_code);
    assign accept = (state == S_IDLE) && op_valid;

    // Stack pointer moves at acceptance so a long mem_busy stall cannot desync it.
    assign stk_push = accept && (op == OP_PUSH) && !stk_full;
    assign stk_pop  = accept && (op == OP_POP)  && !stk_empty;

    mem_bank_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (cur_bank),
        .top   (stk_top),
        .depth (depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // NOTE: all state here is sequential, so every assignment is non-blocking; later
    // assignments in the same block override earlier ones, which gives err-set priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_ready  <= 1'b1;
            bank_ce   <= 1'b0;
            new_bank  <= '0;
            cur_bank  <= '0;
            err       <= 1'b0;
            pend_bank <= '0;
        end else begin
            bank_ce <= 1'b0;
            if (err_clr)
                err <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        unique case (op)
                            OP_SET: begin
                                pend_bank <= op_bank;
                                state     <= S_WAIT;
                                op_ready  <= 1'b0;
                            end
                            OP_PUSH: begin
                                if (stk_full) begin
                                    err <= 1'b1;
                                end else begin
                                    pend_bank <= op_bank;
                                    state     <= S_WAIT;
                                    op_ready  <= 1'b0;
                                end
                            end
                            OP_POP: begin
                                if (stk_empty) begin
                                    err <= 1'b1;
                                end else begin
                                    pend_bank <= stk_top;
                                    state     <= S_WAIT;
                                    op_ready  <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_WAIT: begin
                    if (!mem_busy) begin
                        state    <= S_COMMIT;
                        bank_ce  <= 1'b1;
                        new_bank <= pend_bank;
                    end
                end
                S_COMMIT: begin
                    cur_bank <= new_bank;
                    state    <= S_IDLE;
                    op_ready <= 1'b1;
                end
                default: begin
                    state    <= S_IDLE;
                    op_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Randomised scoreboard bench for mem_bank_ctrl against a queue-based reference model.
module tb_mem_bank_ctrl;

    localparam int WIDTH = 2;
    localparam int DEPTH = 4;
    localparam int DW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             op_valid = 1'b0;
    logic [1:0]       op_code = 2'b11;
    logic [WIDTH-1:0] op_bank = '0;
    logic             op_ready;
    logic             mem_busy = 1'b0;
    logic             bank_ce;
    logic [WIDTH-1:0] new_bank;
    logic [WIDTH-1:0] cur_bank;
    logic [DW-1:0]    depth;
    logic             err;
    logic             err_clr = 1'b0;

    int tests  = 0;
    int failed = 0;

    // Reference model state
    int cur_m = 0;
    int err_m = 0;
    int stack_m[$];
    int sb[$];

    mem_bank_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_code  (op_code),
        .op_bank  (op_bank),
        .op_ready (op_ready),
        .mem_busy (mem_busy),
        .bank_ce  (bank_ce),
        .new_bank (new_bank),
        .cur_bank (cur_bank),
        .depth    (depth),
        .err      (err),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every load-enable pulse must match the oldest outstanding commit.
    always @(negedge clk) begin
        if (!rst && bank_ce) begin
            if (sb.size() == 0) begin
                check("unexpected_bank_ce", 1, 0);
            end else begin
                int e;
                e = sb.pop_front();
                check("new_bank", int'(new_bank), e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_cur_bank"}, int'(cur_bank), cur_m);
        check({tag, "_depth"}, int'(depth), stack_m.size());
        check({tag, "_err"}, int'(err), err_m);
    endtask

    // Issue one operation and follow it to completion; busy = cycles mem_busy stays high in WAIT.
    task automatic do_op(input int code, input int bank, input int busy, input bit clr);
        int  n;
        bit  acc;
        bit  rej;
        int  exp_bank;
        n = 0;
        while (!op_ready && n < 50) begin
            tick();
            n++;
        end
        check("op_ready_timeout", int'(op_ready), 1);

        acc = 0; rej = 0; exp_bank = 0;
        case (code)
            0: begin acc = 1; exp_bank = bank; end
            1: begin
                if (stack_m.size() == DEPTH) rej = 1;
                else begin stack_m.push_back(cur_m); acc = 1; exp_bank = bank; end
            end
            2: begin
                if (stack_m.size() == 0) rej = 1;
                else begin exp_bank = stack_m.pop_back(); acc = 1; end
            end
            default: ;
        endcase
        if (clr) err_m = 0;
        if (rej) err_m = 1;
        if (acc) sb.push_back(exp_bank);

        op_valid = 1'b1;
        op_code  = 2'(code);
        op_bank  = WIDTH'(bank);
        err_clr  = clr;
        mem_busy = (busy > 0);
        tick();
        op_valid = 1'b0;
        op_code  = 2'(3);
        op_bank  = WIDTH'($urandom_range(3));
        err_clr  = 1'b0;

        if (acc) begin
            check("ready_low_wait", int'(op_ready), 0);
            for (int i = 0; i < busy; i++) begin
                tick();
                check("stall_no_ce", int'(bank_ce), 0);
                check("stall_ready", int'(op_ready), 0);
            end
            mem_busy = 1'b0;
            tick();
            check("commit_ce", int'(bank_ce), 1);
            check("commit_ready", int'(op_ready), 0);
            tick();
            cur_m = exp_bank;
            check("post_commit_ce", int'(bank_ce), 0);
            check("post_commit_ready", int'(op_ready), 1);
        end else begin
            mem_busy = 1'b0;
            check("idle_ready", int'(op_ready), 1);
            check("idle_no_ce", int'(bank_ce), 0);
        end
        check_state("op");
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", int'(op_ready), 1);
        check("rst_ce", int'(bank_ce), 0);
        check("rst_new_bank", int'(new_bank), 0);
        check_state("rst");

        // Directed scenarios
        do_op(0, 2, 0, 0);
        do_op(0, 1, 5, 0);
        do_op(0, 0, 0, 0);
        do_op(1, 1, 0, 0);
        do_op(1, 2, 1, 0);
        do_op(2, 0, 0, 0);
        do_op(2, 0, 2, 0);
        for (int i = 0; i < 5; i++) do_op(1, 3, 0, 0);
        for (int i = 0; i < 5; i++) do_op(2, 0, 0, 0);
        check("restored_bank", int'(cur_bank), 0);
        do_op(2, 0, 0, 1);
        check("clr_vs_set", int'(err), 1);
        do_op(3, 0, 0, 1);
        check("clr_alone", int'(err), 0);
        do_op(0, 2, 0, 0);

        // Reset while an operation waits in WAIT
        op_valid = 1'b1; op_code = 2'(0); op_bank = WIDTH'(3); mem_busy = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_busy = 1'b0;
        cur_m = 0; err_m = 0; stack_m.delete();
        check("rst_wait_ready", int'(op_ready), 1);
        for (int i = 0; i < 4; i++) tick();
        check_state("rst_wait");

        // Randomised traffic
        for (int i = 0; i < 80; i++) begin
            do_op(int'($urandom_range(3)), int'($urandom_range(3)),
                  ($urandom_range(3) == 0) ? int'($urandom_range(4)) : 0,
                  ($urandom_range(7) == 0));
        end

        tick();
        tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
